// File: rtl/opb_region_decoder_pkg.sv
// Shared types and helpers for the OPB region decoder: FSM encoding, field widths,
// the errored-read fill value and the widened region compare.
package opb_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } dec_state_t;

   localparam int LAT_W      = 4;
   localparam int ERR_CNT_W  = 8;
   localparam int MAX_ADDR_W = 64;

   localparam logic [31:0] DEFAULT_DATA = 32'hDEAD_BEEF;

   // base+size is formed one bit wider so a region ending at the top of the
   // address space does not wrap around and match low addresses.
   function automatic logic region_hit(input logic [MAX_ADDR_W-1:0] addr,
                                       input logic [MAX_ADDR_W-1:0] base,
                                       input logic [MAX_ADDR_W-1:0] size);
      logic [MAX_ADDR_W:0] limit;
      limit = {1'b0, base} + {1'b0, size};
      return (size != '0) && (addr >= base) && ({1'b0, addr} < limit);
   endfunction

endpackage

// File: rtl/opb_region_decoder_if.sv
// Bridge-side request/response bus of the OPB region decoder, plus the
// per-slave strobe and read-data lanes toward the peripheral register blocks.
interface opb_region_decoder_if #(
   parameter int NUM_SLAVES = 8,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   logic                         DEC_RE;
   logic                         DEC_WE;
   logic [ADDR_W-1:0]            DEC_ADDR;
   logic [DATA_W-1:0]            DEC_DO;
   logic                         DEC_ACK;
   logic                         DEC_ERR;
   logic                         DEC_BUSY;
   logic [NUM_SLAVES*DATA_W-1:0] SLV_DI;
   logic [NUM_SLAVES-1:0]        SLV_RE;
   logic [NUM_SLAVES-1:0]        SLV_WE;

   // Handshake: DEC_RE/DEC_WE act as request-valid and ~DEC_BUSY as ready; a
   // request is taken only in a cycle with DEC_BUSY low and is answered by
   // exactly one DEC_ACK pulse, which qualifies DEC_ERR and DEC_DO. Requests
   // shown while DEC_BUSY is high are dropped, never queued.
   modport slave (
      input  DEC_RE, DEC_WE, DEC_ADDR, SLV_DI,
      output DEC_DO, DEC_ACK, DEC_ERR, DEC_BUSY, SLV_RE, SLV_WE
   );

   modport master (
      output DEC_RE, DEC_WE, DEC_ADDR, SLV_DI,
      input  DEC_DO, DEC_ACK, DEC_ERR, DEC_BUSY, SLV_RE, SLV_WE
   );

endinterface

// File: rtl/opb_region_decoder_match.sv
// Single-region address comparator; one instance per decoded slave.
module opb_region_match
   import opb_dec_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] size,
   output logic              hit
);

   assign hit = region_hit(MAX_ADDR_W'(addr), MAX_ADDR_W'(base), MAX_ADDR_W'(size));

endmodule

// File: rtl/opb_region_decoder.sv
// OPB address decoder: one-hot slave strobes, per-slave read latency, error
// response with sticky status, address capture and saturating error count.
module opb_region_decoder
   import opb_dec_pkg::*;
#(
   parameter int                           NUM_SLAVES   = 8,
   parameter int                           ADDR_W       = 32,
   parameter int                           DATA_W       = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS   = {32'h0000_0700, 32'h0000_0600,
                                                           32'h0000_0500, 32'h0000_0400,
                                                           32'h0000_0300, 32'h0000_0200,
                                                           32'h0000_0100, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SIZES        = {32'h0, 32'h0,
                                                           {6{32'h0000_0100}}},
   parameter logic [NUM_SLAVES*LAT_W-1:0]  RD_LAT       = {NUM_SLAVES{4'd1}},
   parameter logic [DATA_W-1:0]            DEFAULT_DATA = DATA_W'(opb_dec_pkg::DEFAULT_DATA)
) (
   input  logic                   OPB_CLK,
   input  logic                   OPB_RST,
   opb_region_decoder_if.slave    bus,
   input  logic                   ERR_CLR,
   output logic                   ERR_VALID,
   output logic [ADDR_W-1:0]      ERR_ADDR,
   output logic [ERR_CNT_W-1:0]   ERR_CNT,
   output dec_state_t             dbg_state
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 32) begin : g_bad_num_slaves
      $error("opb_region_decoder: NUM_SLAVES must be 1..32");
   end

   // ---------------------------------------------------------------- decode
   logic [NUM_SLAVES-1:0] raw_hit;
   logic [LAT_W-1:0]      lat_tab [NUM_SLAVES];

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
      opb_region_match #(
         .ADDR_W (ADDR_W)
      ) u_match (
         .addr (bus.DEC_ADDR),
         .base (BASE_ADDRS[g*ADDR_W +: ADDR_W]),
         .size (SIZES[g*ADDR_W +: ADDR_W]),
         .hit  (raw_hit[g])
      );

      assign lat_tab[g] = RD_LAT[g*LAT_W +: LAT_W];

      if (RD_LAT[g*LAT_W +: LAT_W] == '0) begin : g_bad_lat
         $error("opb_region_decoder: RD_LAT of every slave must be 1..15");
      end
   end

   // Overlapping regions resolve to the lowest index, so the scan runs downward
   // and the last match written is the winner.
   logic [NUM_SLAVES-1:0] hit_oh;
   logic [IDX_W-1:0]      hit_idx;
   logic                  any_hit;

   always_comb begin
      hit_oh  = '0;
      hit_idx = '0;
      any_hit = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (raw_hit[i]) begin
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
            hit_idx   = IDX_W'(i);
            any_hit   = 1'b1;
         end
      end
   end

   // --------------------------------------------------------- request logic
   dec_state_t       state, state_d;
   logic [LAT_W-1:0] cnt, cnt_d;
   logic [IDX_W-1:0] sel, sel_d;
   logic             err_q, err_d;
   logic             rd_q, rd_d;

   logic             is_idle;
   logic             rd_req;
   logic             wr_req;
   logic             accept;
   logic             acc_err;
   logic [LAT_W-1:0] hit_lat;

   assign is_idle = (state == ST_IDLE);
   assign rd_req  = bus.DEC_RE & ~bus.DEC_WE;
   assign wr_req  = bus.DEC_WE & ~bus.DEC_RE;
   assign accept  = is_idle & (bus.DEC_RE | bus.DEC_WE);
   assign acc_err = accept & ((bus.DEC_RE & bus.DEC_WE) | ~any_hit);
   assign hit_lat = lat_tab[hit_idx];

   assign bus.SLV_RE = (is_idle & rd_req) ? hit_oh : '0;
   assign bus.SLV_WE = (is_idle & wr_req) ? hit_oh : '0;

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sel   <= '0;
         err_q <= 1'b0;
         rd_q  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         sel   <= sel_d;
         err_q <= err_d;
         rd_q  <= rd_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sel_d   = sel;
      err_d   = err_q;
      rd_d    = rd_q;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               sel_d = hit_idx;
               rd_d  = bus.DEC_RE;
               err_d = acc_err;
               if (!acc_err && rd_req && hit_lat != LAT_W'(1)) begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = hit_lat - LAT_W'(1);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RD_WAIT: begin
            if (cnt == LAT_W'(1)) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- response
   logic [DATA_W-1:0] slv_rdata;

   assign slv_rdata = bus.SLV_DI[sel*DATA_W +: DATA_W];

   // Read data is taken live from the selected slave during the response cycle.
   always_comb begin
      bus.DEC_DO = '0;
      if (state == ST_RESP && rd_q) begin
         bus.DEC_DO = err_q ? DEFAULT_DATA : slv_rdata;
      end
   end

   assign bus.DEC_ACK  = (state == ST_RESP);
   assign bus.DEC_ERR  = (state == ST_RESP) & err_q;
   assign bus.DEC_BUSY = ~is_idle;
   assign dbg_state    = state;

   // ----------------------------------------------------------- error status
   // A new error outranks a simultaneous clear: it restarts the count at one.
   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         ERR_VALID <= 1'b0;
         ERR_ADDR  <= '0;
         ERR_CNT   <= '0;
      end else if (acc_err) begin
         ERR_VALID <= 1'b1;
         ERR_ADDR  <= bus.DEC_ADDR;
         if (ERR_CLR) begin
            ERR_CNT <= ERR_CNT_W'(1);
         end else if (ERR_CNT != '1) begin
            ERR_CNT <= ERR_CNT + 1'b1;
         end
      end else if (ERR_CLR) begin
         ERR_VALID <= 1'b0;
         ERR_CNT   <= '0;
      end
   end

endmodule
